// File: rtl/axi4_burst_ram_responder_if.sv
// AXI4 burst bus between a master (data mover / bench) and the RAM responder.
// Latency: none, plain wires.
// Backpressure: standard AXI valid/ready on every channel.
interface axi4_burst_ram_responder_if #(
    parameter int DW = 512,
    parameter int AW = 64
);
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wlast;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wvalid, wlast,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wvalid, wlast,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_burst_ram_responder.sv
// AXI4 INCR-burst slave backed by a dual-port RAM; independent read and write channels.
// Latency: WREADY 1 clk after AW, BVALID 1 clk after last W beat, first RVALID 2 clks after AR.
// Backpressure: one burst per channel in flight; R beats hold while RREADY=0, B holds until BREADY.
module axi4_burst_ram_responder #(
    parameter int DW    = 512,
    parameter int AW    = 64,
    parameter int DEPTH = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    axi4_burst_ram_responder_if.slave     s_axi
);
    localparam int OFFW = $clog2(DW / 8);
    localparam int IDXW = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_BUSY}         r_state_t;

    logic [DW-1:0] mem [DEPTH];

    // Write channel state
    w_state_t        w_state;
    logic [IDXW-1:0] w_idx;
    logic [7:0]      w_len;
    logic [7:0]      w_cnt;
    logic            awready_q;
    logic            wready_q;
    logic            bvalid_q;
    logic [1:0]      bresp_q;

    // Read channel state
    r_state_t        r_state;
    logic [IDXW-1:0] r_idx;
    logic [8:0]      r_left;
    logic            arready_q;
    logic            rvalid_q;
    logic            rlast_q;
    logic [DW-1:0]   rdata_q;

    logic w_fire;
    logic r_issue;
    logic w_end;
    logic unused_addr_bits;

    // Byte offset and bits above the RAM index are don't-care.
    assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

    assign w_fire  = wready_q && s_axi.wvalid && !reset;
    assign w_end   = s_axi.wlast || (w_cnt == w_len);
    assign r_issue = (r_state == R_BUSY) && (r_left != 9'd0) && (!rvalid_q || s_axi.rready);

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = RESP_OKAY;

    // RAM write port: per-byte strobes, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Write FSM: accept AW, absorb beats until WLAST or the AWLEN count, then hold B.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state   <= W_IDLE;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (s_axi.awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_idx     <= s_axi.awaddr[IDXW+OFFW-1:OFFW];
                        w_len     <= s_axi.awlen;
                        w_cnt     <= '0;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi.wvalid && wready_q) begin
                        w_idx <= w_idx + 1'b1;
                        w_cnt <= w_cnt + 8'd1;
                        if (w_end) begin
                            // WLAST and the beat count must agree, otherwise the burst was malformed.
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (s_axi.wlast && (w_cnt == w_len)) ? RESP_OKAY : RESP_SLVERR;
                            w_state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: one-clock registered RAM read, issued only when the output slot is free or draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_idx     <= '0;
            r_left    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_axi.arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        r_idx     <= s_axi.araddr[IDXW+OFFW-1:OFFW];
                        r_left    <= {1'b0, s_axi.arlen} + 9'd1;
                        r_state   <= R_BUSY;
                    end
                end
                R_BUSY: begin
                    if (!rvalid_q || s_axi.rready) begin
                        rvalid_q <= r_issue;
                        rlast_q  <= r_issue && (r_left == 9'd1);
                    end
                    if (r_issue) begin
                        rdata_q <= mem[r_idx];
                        r_idx   <= r_idx + 1'b1;
                        r_left  <= r_left - 9'd1;
                    end
                    if (rvalid_q && s_axi.rready && rlast_q) begin
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/axi4_burst_ram_responder.md
Name: axi4_burst_ram_responder

Overview:
AXI4 memory-mapped slave (responder) backed by an internal dual-port block RAM.
- Accepts INCR read and write bursts from an AXI4 master; the primary master is the team's data mover.
- Used as a source or destination target in simulation and on-chip scratch buffers.
- Read and write channels are fully independent. Both sustain one beat per clock.

Parameters:
DW, 512, data width in bits; power of 2, >= 32
AW, 64, address width in bits
DEPTH, 1024, RAM depth in DW-bit words; power of 2

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  AW  write burst start address (byte)
S_AXI_AWLEN  in  8  write beats minus 1
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DW  write data
S_AXI_WSTRB  in  DW/8  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WLAST  in  1  last write beat
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response (0=OKAY, 2=SLVERR)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  AW  read burst start address (byte)
S_AXI_ARLEN  in  8  read beats minus 1
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DW  read data
S_AXI_RRESP  out  2  read response; always 0 (OKAY)
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready

Behaviour:
- Reset (one clock, synchronous, active-high): clears every output to 0, including RDATA; both FSMs go to IDLE; RAM contents are preserved.
- Reset mid-burst: the burst is aborted and no B or R response is issued for it.
- Word index = addr[log2(DEPTH)+log2(DW/8)-1 : log2(DW/8)]. Low byte-offset bits are ignored. The index wraps modulo DEPTH, both at the start address and while incrementing.
- AxSIZE, AxBURST and IDs are not ported. Every burst is treated as INCR with full-width beats.
- Write FSM:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch the index and AWLEN, clear the beat count, go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY beat writes the RAM with per-byte WSTRB enables, then increments the index and the beat count.
  - The burst ends on the beat where WLAST=1 or the beat count reaches AWLEN, whichever comes first.
  - End of burst: set BRESP=SLVERR if those two conditions did not coincide, else OKAY. Go to W_RESP.
  - W_RESP: BVALID=1 and BRESP held stable. On BREADY, return to W_IDLE.
- Write timing:
  - AW handshake in cycle N puts WREADY high in cycle N+1.
  - The last beat in cycle M puts BVALID high in cycle M+1.
  - AWREADY is low from the AW handshake until W_IDLE is re-entered, so at most one write burst is outstanding.
- Read FSM:
  - R_IDLE: ARREADY=1. On handshake, latch the index and set beats_left = ARLEN+1. Go to R_BUSY.
  - R_BUSY: a RAM read is issued whenever beats_left>0 and (RVALID==0 or RREADY==1).
  - Read latency is one clock. RDATA is the registered RAM output and updates only when a read is issued.
  - RVALID(next) = read issued this cycle. RLAST(next) = read issued with beats_left==1.
  - Each issued read increments the index and decrements beats_left.
  - The FSM returns to R_IDLE when the RVALID&RREADY&RLAST handshake occurs.
- Read timing: AR handshake in cycle N gives the first RVALID in cycle N+2. Back-to-back beats follow with RREADY held high.
- Read handshake stability: RVALID/RDATA/RLAST are held stable while RVALID=1 and RREADY=0.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data.
- AW and AR may handshake in the same cycle; the two channels never stall each other.

Test Plan:
- Write AWADDR=0x0, AWLEN=3 with 4 beats, WSTRB all ones, data 0xA0..0xA3, BREADY=1 -> BVALID one cycle after beat 4, BRESP=0. Then read ARADDR=0x0, ARLEN=3 -> RDATA 0xA0..0xA3, RLAST on beat 4 only, first RVALID 2 cycles after AR.
- Read ARLEN=7 with RREADY toggled 1,0,0,1,... -> no beat lost or duplicated, RDATA stable during stalls, exactly 8 handshakes.
- Write AWLEN=3 with WLAST asserted on beat 2 -> burst ends after 2 beats, BRESP=2. A subsequent AW is accepted normally.
- Write word 0 with WSTRB=0x000...0F over prior data 0xFF..FF and new data 0 -> readback low 4 bytes 0, rest 0xFF.
- Write at AWADDR=(DEPTH-1)*64, AWLEN=1 -> beat 2 lands in word 0 (wrap), verified by readback.
- Assert reset mid write burst (beat 2 of 4), then mid read burst -> all outputs 0 next cycle, no BVALID/RVALID issued, AWREADY/ARREADY=1 one cycle after reset deasserts.
